// File: rtl/div_sched.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in the execute stage.
// Optional `DIV_EARLY_OUT_EN skips the iterations when |dividend| < |divisor|.
module div_sched #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               cancel_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIVZERO,
    S_ON,
    S_END
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted, diff;
  logic [WIDTH-1:0]   step_rem, step_quot, fin_rem, fin_quot;
  logic               early;
  logic               stall_c, ready_c;

  assign abs_a = (signed_i && opa_i[WIDTH-1]) ? -opa_i : opa_i;
  assign abs_b = (signed_i && opb_i[WIDTH-1]) ? -opb_i : opb_i;

  // One restoring step: the extra top bit lets the shifted remainder exceed WIDTH bits.
  assign shifted   = {rem_q, quot_q[WIDTH-1]};
  assign diff      = shifted - {1'b0, dvsr_q};
  assign step_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign step_quot = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
  assign fin_quot  = qneg_q ? -step_quot : step_quot;
  assign fin_rem   = rneg_q ? -step_rem : step_rem;

`ifdef DIV_EARLY_OUT_EN
  assign early = (opb_i != '0) && (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    stall_c  = 1'b0;
    ready_c  = 1'b0;
    if (cancel_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            stall_c = 1'b1;
            if (opb_i == '0) begin
              state_d = S_DIVZERO;
              rem_d   = opa_i;
            end else if (early) begin
              state_d  = S_END;
              result_d = {opa_i, {WIDTH{1'b0}}};
            end else begin
              state_d = S_ON;
              quot_d  = abs_a;
              rem_d   = '0;
              dvsr_d  = abs_b;
              qneg_d  = signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
              rneg_d  = signed_i & opa_i[WIDTH-1];
              cnt_d   = '0;
            end
          end
        end
        S_ON: begin
          stall_c = 1'b1;
          quot_d  = step_quot;
          rem_d   = step_rem;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_END;
            result_d = {fin_rem, fin_quot};
          end
        end
        S_DIVZERO: begin
          stall_c  = 1'b1;
          state_d  = S_END;
          result_d = {rem_q, {WIDTH{1'b1}}};
        end
        S_END: begin
          ready_c = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // The IDLE-with-start stall path is combinational, so mask it while reset is held.
  assign stall_o  = stall_c & resetn;
  assign ready_o  = ready_c;
  assign result_o = result_q;

endmodule
